// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encodings, next-PC
// select codes, buffer entry layout and default buffer depth.
package fetch_pkg;

    localparam int unsigned FETCH_DEPTH = 2;

    localparam int unsigned SEL_PC_WIDTH = 2;
    localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_ADD4 = 2'd0;
    localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_JAL  = 2'd1;
    localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_JALR = 2'd2;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef struct packed {
        logic [31:0] code;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// DEPTH-entry synchronous FIFO of 64-bit fetch entries with flush, used as the
// instruction buffer between memory responses and decode.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_DEPTH,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [63:0]      push_data,
    input  logic             pop,
    output logic [63:0]      head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [63:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch unit: issues sequential word requests, buffers in-order
// responses for decode and discards stale responses after a redirect.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = FETCH_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    imem_req,
    output logic [31:0]             imem_addr,
    input  logic                    imem_gnt,
    input  logic                    imem_rvalid,
    input  logic [31:0]             imem_rdata,
    output logic [31:0]             code,
    output logic [31:0]             pc,
    output logic                    code_valid,
    input  logic                    code_ready,
    input  logic [SEL_PC_WIDTH-1:0] pc_sel,
    input  logic                    branch_taken,
    input  logic [31:0]             jump_target,
    output logic                    pc_misalign
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [1:0]       state, state_d;
    logic [31:0]      fetch_pc, fetch_pc_d;
    logic [31:0]      resp_pc, resp_pc_d;
    logic [CNT_W-1:0] outstanding, outstanding_d;
    logic [CNT_W-1:0] drop_cnt, drop_cnt_d;
    logic [CNT_W-1:0] buf_count;
    logic [SUM_W-1:0] in_use;
    logic             buf_full, buf_empty;
    logic             accept, redirect, grant, resp_take, push;
    fetch_entry_t     head, push_entry;

    assign accept    = code_valid & code_ready;
    assign redirect  = accept & ((pc_sel != SEL_PC_ADD4) | branch_taken);
    assign resp_take = imem_rvalid & (outstanding != '0);

    // A slot being popped this cycle is already free for a new request.
    assign in_use    = SUM_W'(outstanding) + SUM_W'(buf_count) - SUM_W'(accept);
    assign imem_req  = (state != ST_BOOT) & ~redirect & (in_use < SUM_W'(DEPTH));
    assign imem_addr = fetch_pc;
    assign grant     = imem_req & imem_gnt;

    assign push       = (state == ST_RUN) & resp_take & ~redirect & ~buf_full;
    assign push_entry = '{code: imem_rdata, pc: resp_pc};

    assign code_valid = ~buf_empty;
    assign code       = buf_empty ? '0 : head.code;
    assign pc         = buf_empty ? RESET_PC : head.pc;

    fetch_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (push),
        .push_data (push_entry),
        .pop       (accept),
        .head      (head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    always_comb begin
        state_d       = state;
        fetch_pc_d    = fetch_pc;
        resp_pc_d     = resp_pc;
        outstanding_d = outstanding;
        drop_cnt_d    = drop_cnt;
        case (state)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (redirect) begin
                    fetch_pc_d    = align_word(jump_target);
                    resp_pc_d     = align_word(jump_target);
                    outstanding_d = '0;
                    drop_cnt_d    = resp_take ? outstanding - CNT_W'(1) : outstanding;
                    state_d       = (drop_cnt_d != '0) ? ST_DRAIN : ST_RUN;
                end else begin
                    if (grant) begin
                        fetch_pc_d = fetch_pc + 32'd4;
                    end
                    if (resp_take) begin
                        resp_pc_d = resp_pc + 32'd4;
                    end
                    if (grant && !resp_take) begin
                        outstanding_d = outstanding + CNT_W'(1);
                    end else if (!grant && resp_take) begin
                        outstanding_d = outstanding - CNT_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // Target-stream requests are tracked in outstanding; stale ones in drop_cnt.
                if (grant) begin
                    fetch_pc_d    = fetch_pc + 32'd4;
                    outstanding_d = outstanding + CNT_W'(1);
                end
                if (imem_rvalid && drop_cnt != '0) begin
                    drop_cnt_d = drop_cnt - CNT_W'(1);
                end
                if (drop_cnt_d == '0) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_BOOT;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            pc_misalign <= 1'b0;
        end else begin
            state       <= state_d;
            fetch_pc    <= fetch_pc_d;
            resp_pc     <= resp_pc_d;
            outstanding <= outstanding_d;
            drop_cnt    <= drop_cnt_d;
            pc_misalign <= redirect & jump_target[1];
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed start-up/stall/redirect scenarios plus random
// memory and decode behaviour, checked against the architectural PC sequence.
module tb_fetch;
    import fetch_pkg::*;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    imem_req, imem_gnt, imem_rvalid;
    logic [31:0]             imem_addr, imem_rdata;
    logic [31:0]             code, pc, jump_target;
    logic                    code_valid, code_ready, branch_taken, pc_misalign;
    logic [SEL_PC_WIDTH-1:0] pc_sel;

    always #5 clk = ~clk;

    fetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .code         (code),
        .pc           (pc),
        .code_valid   (code_valid),
        .code_ready   (code_ready),
        .pc_sel       (pc_sel),
        .branch_taken (branch_taken),
        .jump_target  (jump_target),
        .pc_misalign  (pc_misalign)
    );

    typedef struct { logic [31:0] addr; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [1:0] sel; logic bt; logic [31:0] tgt; } force_t;

    req_t   pend[$];
    force_t force_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc, grants, accepted, mis_count;
    int gnt_pct, rv_pct, lat_min, lat_max, rdy_pct, redir_pct;
    logic        rst_next;
    logic [31:0] exp_pc, exp_target;
    logic        exp_mis, exp_target_req;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_code;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rand_target();
        if ($urandom_range(3) == 0) return 32'hFFFF_FFF0 + $urandom_range(15);
        return $urandom_range(32'h3FF);
    endfunction

    // One clock cycle: drive memory and decode at negedge, sample 1 time unit later.
    task automatic step();
        logic        redir;
        logic [31:0] tgt;
        logic        acc;
        @(negedge clk);
        rst = rst_next;
        redir = 1'b0;
        tgt   = rand_target();
        if (rst) begin
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            code_ready  = 1'b0;
        end else begin
            imem_gnt = ($urandom_range(99) < gnt_pct);
            if (pend.size() > 0 && pend[0].due <= cyc && $urandom_range(99) < rv_pct) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend[0].addr);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
            end
            code_ready = ($urandom_range(99) < rdy_pct);
        end
        pc_sel       = SEL_PC_ADD4;
        branch_taken = 1'b0;
        if (!rst && force_q.size() > 0 && exp_pc == force_q[0].pc) begin
            code_ready = 1'b1;
            if (code_valid) begin
                redir        = 1'b1;
                pc_sel       = force_q[0].sel;
                branch_taken = force_q[0].bt;
                tgt          = force_q[0].tgt;
                void'(force_q.pop_front());
            end
        end else if (!(code_valid && code_ready)) begin
            pc_sel       = 2'($urandom_range(2));
            branch_taken = 1'($urandom_range(1));
        end else if ($urandom_range(99) < redir_pct) begin
            redir = 1'b1;
            case ($urandom_range(3))
                0: pc_sel = SEL_PC_JAL;
                1: pc_sel = SEL_PC_JALR;
                2: branch_taken = 1'b1;
                default: begin pc_sel = SEL_PC_JAL; branch_taken = 1'b1; end
            endcase
        end
        jump_target = tgt;
        #1;
        s_req = imem_req; s_addr = imem_addr; s_valid = code_valid; s_pc = pc; s_code = code;
        if (rst) begin
            pend.delete();
        end else begin
            if (exp_target_req) begin
                check("redirect_req", imem_req, 1);
                check("redirect_addr", imem_addr, exp_target);
                exp_target_req = 1'b0;
            end
            if (pc_misalign || exp_mis) check("misalign", pc_misalign, exp_mis);
            if (pc_misalign) mis_count++;
            if (imem_req) check("addr_align", imem_addr[1:0], 0);
            acc = code_valid & code_ready;
            if (acc) begin
                check("pc", pc, exp_pc);
                check("code", code, mem_word(exp_pc));
                accepted++;
                if (redir) begin
                    exp_pc         = align_word(tgt);
                    exp_target     = align_word(tgt);
                    exp_target_req = 1'b1;
                end else begin
                    exp_pc = exp_pc + 32'd4;
                end
            end
            exp_mis = acc & redir & tgt[1];
            if (imem_rvalid) void'(pend.pop_front());
            if (imem_req && imem_gnt) begin
                pend.push_back('{imem_addr, cyc + int'($urandom_range(lat_min, lat_max))});
                grants++;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst_next = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_req", s_req, 0);
            check("rst_valid", s_valid, 0);
            check("rst_misalign", pc_misalign, 0);
            check("rst_code", s_code, 0);
            check("rst_pc", s_pc, RESET_PC);
        end
        rst_next       = 1'b0;
        cyc            = 0;
        grants         = 0;
        exp_pc         = RESET_PC;
        exp_mis        = 1'b0;
        exp_target_req = 1'b0;
        force_q.delete();
    endtask

    task automatic set_mode(input int g, input int rv, input int lmin, input int lmax,
                            input int rdy, input int rd);
        gnt_pct = g; rv_pct = rv; lat_min = lmin; lat_max = lmax; rdy_pct = rdy; redir_pct = rd;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; code_ready = 0;
        pc_sel = SEL_PC_ADD4; branch_taken = 0; jump_target = 0;
        accepted = 0; mis_count = 0; cyc = 0; grants = 0;
        exp_pc = RESET_PC; exp_mis = 0; exp_target_req = 0; rst_next = 1'b1;
        set_mode(100, 100, 1, 1, 100, 0);

        // Start-up streaming with single-cycle memory and an always-ready decoder.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) check("boot_req", s_req, 0);
            if (i >= 1 && i <= 3) begin
                check("start_req", s_req, 1);
                check("start_addr", s_addr, 32'(4 * (i - 1)));
            end
            if (i < 3) check("start_valid_early", s_valid, 0);
            if (i >= 3 && i <= 5) begin
                check("start_valid", s_valid, 1);
                check("start_pc", s_pc, 32'(4 * (i - 3)));
            end
        end

        // Decode stalled: requests limited to the buffer depth.
        set_mode(100, 100, 1, 1, 0, 0);
        do_reset();
        for (int i = 0; i < 12; i++) step();
        check("stall_grants", grants, DEPTH);
        check("stall_req", s_req, 0);
        check("stall_valid", s_valid, 1);
        check("stall_pc", s_pc, 32'h0);
        rdy_pct = 100;
        for (int i = 0; i < 6; i++) step();

        // Directed redirects: JAL with stale responses in flight, then misaligned JALR.
        set_mode(100, 100, 3, 3, 100, 0);
        do_reset();
        mis_count = 0;
        force_q.push_back('{32'h8, SEL_PC_JAL, 1'b0, 32'h100});
        force_q.push_back('{32'h104, SEL_PC_JALR, 1'b0, 32'h202});
        for (int i = 0; i < 60; i++) step();
        check("force_done", force_q.size(), 0);
        check("misalign_pulses", mis_count, 1);
        check("after_jalr_pc", (exp_pc >= 32'h204) ? 1 : 0, 1);

        // Random stalls and redirects, with a reset part-way through.
        for (int half = 0; half < 2; half++) begin
            int start;
            set_mode(70, 75, 1, 4, 70, 12);
            do_reset();
            start = accepted;
            for (int i = 0; i < 15000 && (accepted - start) < 600; i++) step();
            check("random_progress", ((accepted - start) >= 600) ? 1 : 0, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 2: instruction buffer entries, which also caps outstanding memory requests.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  instruction memory request valid.
REQ-006 imem_addr  output  32  word-aligned request address.
REQ-007 imem_gnt  input  1  request accepted this cycle when imem_req is also high.
REQ-008 imem_rvalid  input  1  response data valid; responses return in request order, latency >=1 cycle.
REQ-009 imem_rdata  input  32  response instruction word.
REQ-010 code  output  32  instruction to decode; from buffer head.
REQ-011 pc  output  32  address of code.
REQ-012 code_valid  output  1  code/pc valid.
REQ-013 code_ready  input  1  decode accepts code this cycle.
REQ-014 pc_sel  input  SEL_PC_WIDTH  next-PC select for the accepted instruction (SEL_PC_ADD4/JAL/JALR).
REQ-015 branch_taken  input  1  accepted instruction is a taken branch.
REQ-016 jump_target  input  32  redirect target for JAL/JALR/taken branch.
REQ-017 pc_misalign  output  1  one-cycle pulse: redirect target had bit 1 set.

Function
REQ-018 Accept = code_valid & code_ready; accept pops the buffer head.
REQ-019 Redirect = accept & (pc_sel != SEL_PC_ADD4 | branch_taken); sampled only on accept.
REQ-020 States: BOOT (first cycle after reset), RUN, DRAIN; state encodings defined in the shared header.
REQ-021 BOOT -> RUN unconditionally; imem_req is 0 in BOOT.
REQ-022 In RUN and DRAIN, imem_req = 1 iff outstanding + buffered < DEPTH; imem_addr = fetch_pc.
REQ-023 On grant (imem_req & imem_gnt), fetch_pc += 4 and outstanding += 1 (32-bit wrap at 32'hFFFF_FFFC -> 0).
REQ-024 Each imem_rvalid decrements outstanding.
REQ-025 In RUN, each imem_rvalid pushes {imem_rdata, address} into the buffer; code_valid rises the following cycle (registered, no bypass).
REQ-026 Push and pop in the same cycle leave occupancy unchanged.
REQ-027 On redirect: flush buffer; fetch_pc <= {jump_target[31:2], 2'b00}; drop_cnt <= outstanding minus any rvalid that cycle; next state DRAIN if the resulting drop_cnt > 0, else RUN.
REQ-028 A redirect cycle's own imem_rvalid and imem_gnt are discarded; no request is issued to the old stream after redirect.
REQ-029 First target request is issued the cycle after redirect, in either RUN or DRAIN.
REQ-030 In DRAIN, each imem_rvalid is discarded and decrements drop_cnt; DRAIN -> RUN when drop_cnt reaches 0, on the same cycle the last stale response arrives.
REQ-031 Responses to target-stream requests issued during DRAIN are counted separately and pushed once past drop_cnt.
REQ-032 pc_misalign = 1 the cycle after a redirect with jump_target[1] = 1; fetch continues from the aligned address.
REQ-033 imem_rvalid with the buffer full (protocol violation) is ignored and does not corrupt state.

Reset
REQ-034 While rst is high: state = BOOT; fetch_pc = RESET_PC; buffer empty; outstanding = drop_cnt = 0.
REQ-035 While rst is high: imem_req = 0, code_valid = 0, pc_misalign = 0, code = 0, pc = RESET_PC.
REQ-036 Reset mid-operation abandons all outstanding requests; the memory side is reset together with this block.

Structure
REQ-037 Fetch state encodings and DEPTH default go in shared header param_fetch.vh; SEL_PC_* values come from param_pc_mux.vh.
REQ-038 The buffer is a sub-module fetch_buf: a DEPTH-entry synchronous FIFO with push/pop/full/empty and 64-bit entries.

Verification
REQ-039 Reset release, gnt = 1, 1-cycle latency, code_ready = 1 -> imem_addr 0,4,8…; code_valid first high 3 cycles after rst low; pc 0,4,8 on consecutive cycles.
REQ-040 code_ready = 0 for 10 cycles -> at most DEPTH requests granted; buffer holds pc 0 and 4; no imem_req until a pop.
REQ-041 JAL accepted at pc 8 with jump_target 32'h100 and 2 responses outstanding -> both dropped; next imem_addr 32'h100; next code_valid has pc 32'h100.
REQ-042 Taken branch coinciding with imem_rvalid -> that response is not delivered; drop_cnt equals the remaining outstanding count.
REQ-043 JALR with jump_target 32'h202 -> pc_misalign pulses once; next fetch at 32'h200.
REQ-044 Random gnt/rvalid stalls (latency 1-4) over 1000 instructions -> delivered pc sequence matches the reference model exactly, with no duplicates or losses.
